// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the synchronous FIFO controller: default sizing,
// status-flag bit positions and the flag derivation used at every clock edge.
package fifo_ctrl_pkg;

    localparam int AWIDTH_DEF    = 7;
    localparam int AFULL_TH_DEF  = 120;
    localparam int AEMPTY_TH_DEF = 8;
    localparam int RD_LAT_DEF    = 1;

    localparam int FLAG_FULL   = 0;
    localparam int FLAG_EMPTY  = 1;
    localparam int FLAG_AFULL  = 2;
    localparam int FLAG_AEMPTY = 3;
    localparam int NUM_FLAGS   = 4;

    typedef logic [NUM_FLAGS-1:0] flags_t;

    // Flags are a pure function of the occupancy they will describe.
    function automatic flags_t calc_flags(input int unsigned count,
                                          input int unsigned depth,
                                          input int unsigned afull_th,
                                          input int unsigned aempty_th);
        flags_t f;
        f              = '0;
        f[FLAG_FULL]   = (count == depth);
        f[FLAG_EMPTY]  = (count == 0);
        f[FLAG_AFULL]  = (count >= afull_th);
        f[FLAG_AEMPTY] = (count <= aempty_th);
        return f;
    endfunction

    function automatic flags_t reset_flags();
        flags_t f;
        f              = '0;
        f[FLAG_EMPTY]  = 1'b1;
        f[FLAG_AEMPTY] = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/fifo_rd_lat_pipe.sv
// Delays the accepted-read strobe by the RAM read latency to form DVLD.
// Reset empties the pipe so reads issued before reset never produce DVLD.
module fifo_rd_lat_pipe #(
    parameter int LAT = 1
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic din,
    output logic dout
);

    logic [LAT-1:0] sr;

    generate
        if (LAT == 1) begin : g_single
            always_ff @(posedge CLOCK or posedge RESET) begin
                if (RESET) sr <= '0;
                else       sr <= din;
            end
        end else begin : g_multi
            always_ff @(posedge CLOCK or posedge RESET) begin
                if (RESET) sr <= '0;
                else       sr <= {sr[LAT-2:0], din};
            end
        end
    endgenerate

    assign dout = sr[LAT-1];

endmodule

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO controller driving an external RAM: pointers, occupancy,
// registered status flags, request acknowledge/reject strobes and read-data valid.
module fifo_sync_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int AWIDTH    = AWIDTH_DEF,
    parameter int AFULL_TH  = AFULL_TH_DEF,
    parameter int AEMPTY_TH = AEMPTY_TH_DEF,
    parameter int RD_LAT    = RD_LAT_DEF
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              WE,
    input  logic              RE,
    output logic [AWIDTH-1:0] MEM_WADDR,
    output logic              MEM_WEN,
    output logic [AWIDTH-1:0] MEM_RADDR,
    output logic              MEM_REN,
    output logic              FULL,
    output logic              EMPTY,
    output logic              AFULL,
    output logic              AEMPTY,
    output logic              WACK,
    output logic              DVLD,
    output logic              OVERFLOW,
    output logic              UNDERFLOW,
    output logic [AWIDTH:0]   COUNT
);

    localparam int DEPTH = 2 ** AWIDTH;

    logic [AWIDTH-1:0] wptr;
    logic [AWIDTH-1:0] rptr;
    logic [AWIDTH:0]   count;
    logic [AWIDTH:0]   count_nxt;
    flags_t            flags;
    flags_t            flags_nxt;
    logic              wr_ok;
    logic              rd_ok;

    // Request handshake: WE/RE act as valid, the registered !FULL / !EMPTY act
    // as ready; a request is consumed on the edge where both are high, and a
    // request that is not consumed has no effect beyond the reject strobe.
    assign wr_ok = WE & ~flags[FLAG_FULL];
    assign rd_ok = RE & ~flags[FLAG_EMPTY];

    assign MEM_WEN   = wr_ok;
    assign MEM_WADDR = wptr;
    assign MEM_REN   = rd_ok;
    assign MEM_RADDR = rptr;

    always_comb begin
        count_nxt = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + (AWIDTH + 1)'(1);
            2'b01:   count_nxt = count - (AWIDTH + 1)'(1);
            default: count_nxt = count;
        endcase
    end

    assign flags_nxt = calc_flags(32'(count_nxt), DEPTH, AFULL_TH, AEMPTY_TH);

    // Pointers are exactly AWIDTH bits wide so the increment wraps naturally.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            flags     <= reset_flags();
            WACK      <= 1'b0;
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else begin
            if (wr_ok) wptr <= wptr + AWIDTH'(1);
            if (rd_ok) rptr <= rptr + AWIDTH'(1);
            count     <= count_nxt;
            flags     <= flags_nxt;
            WACK      <= wr_ok;
            OVERFLOW  <= WE & flags[FLAG_FULL];
            UNDERFLOW <= RE & flags[FLAG_EMPTY];
        end
    end

    fifo_rd_lat_pipe #(
        .LAT (RD_LAT)
    ) u_rd_lat_pipe (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .din   (rd_ok),
        .dout  (DVLD)
    );

    assign COUNT  = count;
    assign FULL   = flags[FLAG_FULL];
    assign EMPTY  = flags[FLAG_EMPTY];
    assign AFULL  = flags[FLAG_AFULL];
    assign AEMPTY = flags[FLAG_AEMPTY];

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Bench for fifo_sync_ctrl: two instances (read latency 1 and 2) share one
// request stream and are checked every cycle against an occupancy/queue model.
module tb_fifo_sync_ctrl;

    localparam int AW    = 7;
    localparam int DEPTH = 128;
    localparam int AF_TH = 120;
    localparam int AE_TH = 8;

    logic          CLOCK;
    logic          RESET;
    logic          WE;
    logic          RE;

    logic [AW-1:0] waddr1, raddr1, waddr2, raddr2;
    logic          wen1, ren1, full1, empty1, afull1, aempty1, wack1, dvld1, ovf1, udf1;
    logic          wen2, ren2, full2, empty2, afull2, aempty2, wack2, dvld2, ovf2, udf2;
    logic [AW:0]   count1, count2;

    fifo_sync_ctrl #(.AWIDTH(AW), .AFULL_TH(AF_TH), .AEMPTY_TH(AE_TH), .RD_LAT(1)) u_dut1 (
        .CLOCK(CLOCK), .RESET(RESET), .WE(WE), .RE(RE),
        .MEM_WADDR(waddr1), .MEM_WEN(wen1), .MEM_RADDR(raddr1), .MEM_REN(ren1),
        .FULL(full1), .EMPTY(empty1), .AFULL(afull1), .AEMPTY(aempty1),
        .WACK(wack1), .DVLD(dvld1), .OVERFLOW(ovf1), .UNDERFLOW(udf1), .COUNT(count1)
    );

    fifo_sync_ctrl #(.AWIDTH(AW), .AFULL_TH(AF_TH), .AEMPTY_TH(AE_TH), .RD_LAT(2)) u_dut2 (
        .CLOCK(CLOCK), .RESET(RESET), .WE(WE), .RE(RE),
        .MEM_WADDR(waddr2), .MEM_WEN(wen2), .MEM_RADDR(raddr2), .MEM_REN(ren2),
        .FULL(full2), .EMPTY(empty2), .AFULL(afull2), .AEMPTY(aempty2),
        .WACK(wack2), .DVLD(dvld2), .OVERFLOW(ovf2), .UNDERFLOW(udf2), .COUNT(count2)
    );

    // ---------------- clock / reset ----------------
    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    // ---------------- scoreboard bookkeeping ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_count = 0;
    int          m_wptr  = 0;
    int          m_rptr  = 0;
    bit          m_wack  = 0;
    bit          m_ovf   = 0;
    bit          m_udf   = 0;
    bit          m_hist0 = 0;   // read accepted at the most recent edge
    bit          m_hist1 = 0;   // read accepted one edge earlier
    logic [15:0] ram [DEPTH];
    logic [15:0] exp_q [$];
    logic [15:0] wdata   = 16'd0;
    logic [AW-1:0] s_waddr = '0;

    initial begin
        forever begin
            @(posedge CLOCK or posedge RESET);
            if (RESET) begin
                m_count = 0; m_wptr = 0; m_rptr = 0;
                m_wack = 0; m_ovf = 0; m_udf = 0;
                m_hist0 = 0; m_hist1 = 0;
                exp_q.delete();
            end else begin
                bit wr, rd;
                wr      = WE && (m_count != DEPTH);
                rd      = RE && (m_count != 0);
                m_wack  = wr;
                m_ovf   = WE && (m_count == DEPTH);
                m_udf   = RE && (m_count == 0);
                m_hist1 = m_hist0;
                m_hist0 = rd;
                if (rd) begin
                    void'(exp_q.pop_front());
                    m_rptr = (m_rptr + 1) % DEPTH;
                end
                if (wr) begin
                    ram[s_waddr] = wdata;
                    exp_q.push_back(wdata);
                    wdata  = wdata + 16'd1;
                    m_wptr = (m_wptr + 1) % DEPTH;
                end
                m_count = m_count + int'(wr) - int'(rd);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge CLOCK) begin
        bit exp_wr, exp_rd;
        exp_wr  = WE && (m_count != DEPTH);
        exp_rd  = RE && (m_count != 0);
        s_waddr = waddr1;
        chk("mem_wen",   int'(wen1),   int'(exp_wr));
        chk("mem_ren",   int'(ren1),   int'(exp_rd));
        chk("mem_waddr", int'(waddr1), m_wptr);
        chk("mem_raddr", int'(raddr1), m_rptr);
        chk("count",     int'(count1), m_count);
        chk("full",      int'(full1),  int'(m_count == DEPTH));
        chk("empty",     int'(empty1), int'(m_count == 0));
        chk("afull",     int'(afull1), int'(m_count >= AF_TH));
        chk("aempty",    int'(aempty1), int'(m_count <= AE_TH));
        chk("wack",      int'(wack1),  int'(m_wack));
        chk("overflow",  int'(ovf1),   int'(m_ovf));
        chk("underflow", int'(udf1),   int'(m_udf));
        chk("dvld_lat1", int'(dvld1),  int'(m_hist0));
        chk("dvld_lat2", int'(dvld2),  int'(m_hist1));
        chk("lat2_count", int'(count2), m_count);
        chk("lat2_addr", int'({waddr2, raddr2, wen2, ren2}),
            int'({waddr1, raddr1, wen1, ren1}));
        chk("lat2_flags", int'({full2, empty2, afull2, aempty2, wack2, ovf2, udf2}),
            int'({full1, empty1, afull1, aempty1, wack1, ovf1, udf1}));
        if (exp_rd && exp_q.size() > 0)
            chk("rd_data_order", int'(ram[raddr1]), int'(exp_q[0]));
    end

    // ---------------- driver tasks ----------------
    task automatic cycle(input bit we, input bit re);
        WE = we;
        RE = re;
        @(posedge CLOCK);
        #1;
        WE = 1'b0;
        RE = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int guard;
        RESET = 1'b1;
        WE    = 1'b0;
        RE    = 1'b0;
        repeat (3) @(posedge CLOCK);
        #1 RESET = 1'b0;

        chk("rst_empty",  int'(empty1),  1);
        chk("rst_aempty", int'(aempty1), 1);
        chk("rst_full",   int'(full1),   0);
        chk("rst_afull",  int'(afull1),  0);
        chk("rst_count",  int'(count1),  0);

        // Fill to full with 128 writes.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1, 0);
            if (i == AF_TH - 2) chk("afull_119", int'(afull1), 0);
            if (i == AF_TH - 1) chk("afull_120", int'(afull1), 1);
            if (i == DEPTH - 2) chk("full_127",  int'(full1),  0);
        end
        chk("fill_full",  int'(full1),  1);
        chk("fill_count", int'(count1), 128);
        chk("fill_waddr", int'(waddr1), 0);

        // Simultaneous request while full: read wins, write overflows.
        WE = 1'b1; RE = 1'b1;
        #1;
        chk("full_both_ren", int'(ren1), 1);
        chk("full_both_wen", int'(wen1), 0);
        @(posedge CLOCK); #1;
        WE = 1'b0; RE = 1'b0;
        chk("ovf_flag",  int'(ovf1),   1);
        chk("ovf_wack",  int'(wack1),  0);
        chk("ovf_count", int'(count1), 127);
        chk("ovf_full",  int'(full1),  0);
        chk("ovf_raddr", int'(raddr1), 1);

        // Four back-to-back reads, then idle: DVLD shape for both latencies.
        for (int i = 0; i < 6; i++) begin
            cycle(i < 4, 0) ;
        end
        for (int i = 0; i < 6; i++) begin
            cycle(0, i < 4);
            chk("burst_dvld1", int'(dvld1), int'(i < 4));
            chk("burst_dvld2", int'(dvld2), int'(i >= 1 && i < 5));
        end

        // Drain to empty.
        guard = 0;
        while (!empty1 && guard < 300) begin
            cycle(0, 1);
            guard++;
        end
        chk("drain_timeout", int'(guard < 300), 1);
        cycle(0, 0);
        chk("drained_count", int'(count1), 0);

        // Simultaneous request while empty: write wins, read underflows.
        cycle(1, 1);
        chk("udf_flag",  int'(udf1),   1);
        chk("udf_wack",  int'(wack1),  1);
        chk("udf_count", int'(count1), 1);
        chk("udf_empty", int'(empty1), 0);
        chk("udf_dvld1", int'(dvld1),  0);
        cycle(0, 0);
        chk("udf_dvld2", int'(dvld2),  0);

        // Random traffic, write-biased at first then read-biased.
        for (int i = 0; i < 200; i++) begin
            if (i < 120) cycle($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4);
            else         cycle($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 6);
        end

        // Reset with a read in flight at COUNT=5.
        guard = 0;
        while (!empty1 && guard < 300) begin
            cycle(0, 1);
            guard++;
        end
        chk("drain2_timeout", int'(guard < 300), 1);
        repeat (5) cycle(1, 0);
        chk("pre_rst_count", int'(count1), 5);
        cycle(0, 1);
        chk("inflight_dvld1", int'(dvld1), 1);
        #2 RESET = 1'b1;
        #1;
        chk("midrst_empty", int'(empty1), 1);
        chk("midrst_count", int'(count1), 0);
        chk("midrst_dvld1", int'(dvld1),  0);
        chk("midrst_dvld2", int'(dvld2),  0);
        repeat (2) @(posedge CLOCK);
        #1 RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0);
            chk("postrst_dvld2", int'(dvld2), 0);
        end
        chk("postrst_aempty", int'(aempty1), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time bound in case stimulus stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
